// File: rtl/pe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pe_pkg : shared widths, saturation limits and sequencer state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package pe_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 12;
  localparam int ACC_W     = 24;

  localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] c_res_max = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] c_res_min = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sm_fixed_mult.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sm_fixed_mult : combinational sign-magnitude fixed-point multiply
// Rev 1.0
// ----------------------------------------------------------------------------
module sm_fixed_mult
  import pe_pkg::*;
#(
  parameter int DATA_W    = pe_pkg::DATA_W,
  parameter int FRAC_BITS = pe_pkg::FRAC_BITS,
  parameter int ACC_W     = pe_pkg::ACC_W
) (
  input  logic [DATA_W-1:0]        a,
  input  logic [DATA_W-1:0]        b,
  output logic signed [ACC_W-1:0]  prod
);

  localparam int c_full_w = 2 * (DATA_W - 1);

  logic [c_full_w-1:0] w_full;
  logic [c_full_w-1:0] w_shift;
  logic [ACC_W-1:0]    w_mag;
  logic                w_neg;

  assign w_full  = {{(DATA_W-1){1'b0}}, a[DATA_W-2:0]} *
                   {{(DATA_W-1){1'b0}}, b[DATA_W-2:0]};
  // Truncate the magnitude first so negative results round toward zero
  assign w_shift = w_full >> FRAC_BITS;
  assign w_mag   = ACC_W'(w_shift);
  assign w_neg   = a[DATA_W-1] ^ b[DATA_W-1];
  assign prod    = w_neg ? -$signed(w_mag) : $signed(w_mag);

endmodule
`default_nettype wire

// File: rtl/vector_mac_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vector_mac_sequencer : streams one dot product through a single multiplier
// Rev 1.0
// ----------------------------------------------------------------------------
module vector_mac_sequencer
  import pe_pkg::*;
#(
  parameter int DATA_W    = pe_pkg::DATA_W,
  parameter int FRAC_BITS = pe_pkg::FRAC_BITS,
  parameter int ACC_W     = pe_pkg::ACC_W,
  parameter int ADDR_W    = 8,
  parameter int LEN_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res,
  output logic              res_ovf,
  output logic              busy
);

  localparam logic signed [ACC_W-1:0] c_sat_hi = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_sat_lo = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] c_clamp_hi = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] c_clamp_lo = ~c_clamp_hi;

  state_e                   r_state;
  logic [LEN_W-1:0]         r_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_ovf;
  logic                     r_acc_en;

  logic signed [ACC_W-1:0]  w_prod;
  logic signed [ACC_W:0]    w_sum;
  logic                     w_add_ovf;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [ACC_W-1:0]  w_acc_fin;
  logic                     w_ovf_fin;
  logic                     w_clamp_hi;
  logic                     w_clamp_lo;
  logic [DATA_W-1:0]        w_res;
  logic                     w_res_ovf;

  sm_fixed_mult #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS),
    .ACC_W     (ACC_W)
  ) u_mult (
    .a    (rd_data_a),
    .b    (rd_data_b),
    .prod (w_prod)
  );

  // One guard bit detects two's-complement overflow of the accumulate
  assign w_sum      = {r_acc[ACC_W-1], r_acc} + {w_prod[ACC_W-1], w_prod};
  assign w_add_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_acc_next = w_add_ovf ? (w_sum[ACC_W] ? c_sat_lo : c_sat_hi)
                                : w_sum[ACC_W-1:0];

  // Result is formed from the value the accumulator takes at this edge
  assign w_acc_fin  = r_acc_en ? w_acc_next : r_acc;
  assign w_ovf_fin  = r_ovf | (r_acc_en & w_add_ovf);
  assign w_clamp_hi = w_acc_fin > c_clamp_hi;
  assign w_clamp_lo = w_acc_fin < c_clamp_lo;
  assign w_res      = w_clamp_hi ? c_clamp_hi[DATA_W-1:0] :
                      w_clamp_lo ? c_clamp_lo[DATA_W-1:0] :
                                   w_acc_fin[DATA_W-1:0];
  assign w_res_ovf  = w_ovf_fin | w_clamp_hi | w_clamp_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_acc_en    <= 1'b0;
      start_ready <= 1'b1;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      res_valid   <= 1'b0;
      res         <= '0;
      res_ovf     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_acc_en <= rd_en;
      if (r_acc_en) begin
        r_acc <= w_acc_next;
        r_ovf <= w_ovf_fin;
      end

      case (r_state)
        IDLE: begin
          if (start_valid && start_ready) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            rd_addr     <= base_addr;
            r_cnt       <= len - 1'b1;
            if (len != '0) begin
              r_state <= ISSUE;
              rd_en   <= 1'b1;
            end else begin
              r_state   <= DONE;
              res_valid <= 1'b1;
              res       <= '0;
              res_ovf   <= 1'b0;
            end
          end
        end

        ISSUE: begin
          if (r_cnt == '0) begin
            rd_en   <= 1'b0;
            r_state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + 1'b1;
            r_cnt   <= r_cnt - 1'b1;
          end
        end

        DRAIN: begin
          r_state   <= DONE;
          res_valid <= 1'b1;
          res       <= w_res;
          res_ovf   <= w_res_ovf;
        end

        DONE: begin
          if (res_ready) begin
            r_state     <= IDLE;
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_mac_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vector_mac_sequencer : directed vector table plus multi-cycle sequences
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_vector_mac_sequencer;

  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  base_addr;
  logic [7:0]  len;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res;
  logic        res_ovf;
  logic        busy;

  vector_mac_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .base_addr   (base_addr),
    .len         (len),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res         (res),
    .res_ovf     (res_ovf),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic [7:0]  addr_log [$];

  // Scratchpad: one-cycle read latency
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr];
      rd_data_b <= mem_b[rd_addr];
    end
  end

  always @(negedge clk) begin
    if (rd_en) addr_log.push_back(rd_addr);
  end

  typedef struct {
    logic [7:0]       base;
    logic [7:0]       len;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [15:0]      res;
    logic             ovf;
  } vec_t;

  vec_t tbl [6];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic set_vec(input int idx, input logic [7:0] b, input logic [7:0] l,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] a2, input logic [15:0] a3,
                         input logic [15:0] b0, input logic [15:0] b1,
                         input logic [15:0] b2, input logic [15:0] b3,
                         input logic [15:0] r, input logic o);
    tbl[idx].base = b;
    tbl[idx].len  = l;
    tbl[idx].a    = {a3, a2, a1, a0};
    tbl[idx].b    = {b3, b2, b1, b0};
    tbl[idx].res  = r;
    tbl[idx].ovf  = o;
  endtask

  task automatic load_nominal();
    mem_a[0] = 16'h0300; mem_a[1] = 16'h0300; mem_a[2] = 16'h8300;
    mem_b[0] = 16'h0300; mem_b[1] = 16'h8300; mem_b[2] = 16'h0300;
  endtask

  // One complete job: handshake, latency, result, address stream, release
  task automatic run_job(input string nm, input logic [7:0] b, input logic [7:0] l,
                         input logic [15:0] er, input logic eo);
    int lat;
    int exp_lat;
    bit ok;
    addr_log.delete();
    check({nm, " start_ready"}, {31'd0, start_ready}, 32'd1);
    start_valid = 1'b1;
    base_addr   = b;
    len         = l;
    @(posedge clk); #1;
    start_valid = 1'b0;
    base_addr   = '0;
    len         = '0;
    lat = 1;
    while (!res_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    exp_lat = (l == 8'd0) ? 1 : int'(l) + 2;
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " res"}, {16'd0, res}, {16'd0, er});
    check({nm, " res_ovf"}, {31'd0, res_ovf}, {31'd0, eo});
    ok = (addr_log.size() == int'(l));
    for (int i = 0; i < addr_log.size() && i < int'(l); i++)
      if (addr_log[i] !== 8'(int'(b) + i)) ok = 1'b0;
    check({nm, " rd_addr seq"}, {31'd0, ok}, 32'd1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({nm, " release"}, {29'd0, res_valid, start_ready, busy}, 32'b010);
  endtask

  initial begin
    bit ok;
    int lat;
    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    base_addr = '0; len = '0; rd_data_a = '0; rd_data_b = '0;
    for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end

    set_vec(0, 8'h00, 8'd3, 16'h0300, 16'h0300, 16'h8300, 16'h0000,
            16'h0300, 16'h8300, 16'h0300, 16'h0000, 16'hFF70, 1'b0);
    set_vec(1, 8'h10, 8'd0, 16'h1234, 16'h0000, 16'h0000, 16'h0000,
            16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    set_vec(2, 8'h20, 8'd4, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
            16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    set_vec(3, 8'h30, 8'd4, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
            16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000, 1'b1);
    set_vec(4, 8'hFE, 8'd3, 16'h8000, 16'h1000, 16'h1000, 16'h0000,
            16'h7FFF, 16'h1000, 16'h9000, 16'h0000, 16'h0000, 1'b0);
    // -tiny*0.5 -> 0, -1.5*2 -> -3.0, -3/4096*0.75 -> -2/4096 (toward zero)
    set_vec(5, 8'h40, 8'd3, 16'h8001, 16'h9800, 16'h8003, 16'h0000,
            16'h0800, 16'h2000, 16'h0C00, 16'h0000, 16'hCFFE, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {22'd0, start_ready, rd_en, rd_addr, res_valid, res_ovf, busy},
          {22'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    check("reset res", {16'd0, res}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < int'(tbl[v].len); i++) begin
        mem_a[8'(int'(tbl[v].base) + i)] = tbl[v].a[i];
        mem_b[8'(int'(tbl[v].base) + i)] = tbl[v].b[i];
      end
      run_job($sformatf("vec%0d", v), tbl[v].base, tbl[v].len, tbl[v].res, tbl[v].ovf);
    end

    // Accumulator saturates high after 33 adds, then 32 subtractions leave 0x1FF
    for (int i = 0; i < 65; i++) begin
      mem_a[8'(128 + i)] = 16'h7FFF;
      mem_b[8'(128 + i)] = (i < 33) ? 16'h7FFF : 16'hFFFF;
    end
    run_job("acc_sat", 8'h80, 8'd65, 16'h01FF, 1'b1);

    for (int i = 0; i < 256; i++) begin mem_a[i] = 16'h1000; mem_b[i] = 16'h0010; end
    run_job("max_len", 8'h00, 8'd255, 16'h0FF0, 1'b0);

    // Backpressure: result held, extra start requests ignored
    load_nominal();
    addr_log.delete();
    start_valid = 1'b1; base_addr = 8'h00; len = 8'd3;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bp valid", {31'd0, res_valid}, 32'd1);
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      start_valid = c[0];
      base_addr   = 8'h55;
      len         = 8'd7;
      @(posedge clk); #1;
      if (!(res_valid && res == 16'hFF70 && !res_ovf && !start_ready && busy)) ok = 1'b0;
    end
    check("bp hold stable", {31'd0, ok}, 32'd1);
    check("bp no reissue", addr_log.size(), 32'd3);
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("bp start_ready", {30'd0, start_ready, res_valid}, 32'b10);

    // Reset asserted during the second issue cycle
    load_nominal();
    start_valid = 1'b1; base_addr = 8'h00; len = 8'd3;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    check("mid rd_en", {31'd0, rd_en}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort outputs", {22'd0, start_ready, rd_en, rd_addr, res_valid, res_ovf, busy},
          {22'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    check("abort res", {16'd0, res}, 32'd0);
    ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (res_valid || rd_en || busy) ok = 1'b0;
    end
    check("abort quiet", {31'd0, ok}, 32'd1);
    run_job("after_abort", 8'h00, 8'd3, 16'hFF70, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
